// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority and a 1-entry hold buffer parks mul/div results.
// Define RF_WRITE_ARB_FWD_EN to add the combinational read-forwarding ports.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic [ADDR_WIDTH-1:0]   wb_waddr,
  input  logic [DATA_WIDTH/8-1:0] wb_wen,
  input  logic [DATA_WIDTH-1:0]   wb_wdata,
  input  logic                    md_valid,
  output logic                    md_ready,
  input  logic [ADDR_WIDTH-1:0]   md_waddr,
  input  logic [DATA_WIDTH-1:0]   md_wdata,
`ifdef RF_WRITE_ARB_FWD_EN
  input  logic [ADDR_WIDTH-1:0]   raddr1,
  input  logic [ADDR_WIDTH-1:0]   raddr2,
  input  logic [DATA_WIDTH-1:0]   rf_rdata1,
  input  logic [DATA_WIDTH-1:0]   rf_rdata2,
  output logic [DATA_WIDTH-1:0]   fwd_rdata1,
  output logic [DATA_WIDTH-1:0]   fwd_rdata2,
`endif
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH/8-1:0] rf_wen,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  output logic                    pipe_stall,
  output logic                    wb_drop_err
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

  state_t                state;
  logic [7:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] hold_waddr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic                  wb_eff;
  logic                  md_accept;

  // Requests with no byte enables or targeting r0 never reach the port.
  assign wb_eff    = wb_valid & (|wb_wen) & (|wb_waddr);
  assign md_ready  = (state == IDLE);
  assign md_accept = md_valid & md_ready & (|md_waddr);

  // Hold buffer payload: only meaningful while state != IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    if (md_accept) begin
      hold_waddr <= md_waddr;
      hold_wdata <= md_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      rf_waddr    <= '0;
      rf_wen      <= '0;
      rf_wdata    <= '0;
      pipe_stall  <= 1'b0;
      wb_drop_err <= 1'b0;
    end else begin
      rf_wen <= '0;
      case (state)
        IDLE: begin
          if (wb_eff) begin
            rf_waddr <= wb_waddr;
            rf_wen   <= wb_wen;
            rf_wdata <= wb_wdata;
          end
          if (md_accept) begin
            state      <= PEND;
            starve_cnt <= '0;
          end
        end
        PEND: begin
          if (wb_eff) begin
            rf_waddr <= wb_waddr;
            rf_wen   <= wb_wen;
            rf_wdata <= wb_wdata;
            if (starve_cnt == STARVE_LAST) begin
              state      <= STALL;
              pipe_stall <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end else begin
            rf_waddr <= hold_waddr;
            rf_wen   <= '1;
            rf_wdata <= hold_wdata;
            state    <= IDLE;
          end
        end
        STALL: begin
          // The hold wins unconditionally; a writeback that ignored the stall is lost.
          rf_waddr   <= hold_waddr;
          rf_wen     <= '1;
          rf_wdata   <= hold_wdata;
          state      <= IDLE;
          pipe_stall <= 1'b0;
          if (wb_eff) wb_drop_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RF_WRITE_ARB_FWD_EN
  function automatic logic [DATA_WIDTH-1:0] fwd_merge(
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [BE_W-1:0]       wen,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] res;
    res = rdata;
    if (raddr == '0) begin
      res = '0;
    end else if (raddr == waddr) begin
      for (int i = 0; i < BE_W; i++)
        if (wen[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  assign fwd_rdata1 = fwd_merge(raddr1, rf_rdata1, rf_waddr, rf_wen, rf_wdata);
  assign fwd_rdata2 = fwd_merge(raddr2, rf_rdata2, rf_waddr, rf_wen, rf_wdata);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (default build; forwarding checks when RF_WRITE_ARB_FWD_EN is defined).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [3:0]  wb_wen = '0;
  logic [31:0] wb_wdata = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_waddr = '0;
  logic [31:0] md_wdata = '0;
  logic [4:0]  rf_waddr;
  logic [3:0]  rf_wen;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic        wb_drop_err;
`ifdef RF_WRITE_ARB_FWD_EN
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rf_rdata1 = '0;
  logic [31:0] rf_rdata2 = '0;
  logic [31:0] fwd_rdata1;
  logic [31:0] fwd_rdata2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wen(wb_wen), .wb_wdata(wb_wdata),
    .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
`ifdef RF_WRITE_ARB_FWD_EN
    .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2),
`endif
    .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .wb_drop_err(wb_drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_waddr = '0; wb_wen = '0; wb_wdata = '0;
    md_valid = 1'b0; md_waddr = '0; md_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL reset_rf_wen got=%h exp=0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got=%h exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
    checks++; if (wb_drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got=%b exp=0", wb_drop_err); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got=%b exp=1", md_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wb_issue();
    wb_valid = 1'b1; wb_waddr = 5'd5; wb_wen = 4'hF; wb_wdata = 32'hDEADBEEF;
    tick();
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL t1_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wen !== 4'hF) begin errors++; $display("FAIL t1_wen got=%h exp=f", rf_wen); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_wdata got=%h exp=deadbeef", rf_wdata); end
    idle_inputs();
    tick();
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t1_idle_wen got=%h exp=0", rf_wen); end
  endtask

  task automatic test_md_issue();
    md_valid = 1'b1; md_waddr = 5'd7; md_wdata = 32'h12345678;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_pre got=%b exp=1", md_ready); end
    tick();
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_held got=%b exp=0", md_ready); end
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t2_wen_accept got=%h exp=0", rf_wen); end
    // Second result offered immediately; it must wait out the issue edge.
    md_waddr = 5'd8; md_wdata = 32'h0BADF00D;
    tick();
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL t2_waddr got=%0d exp=7", rf_waddr); end
    checks++; if (rf_wen !== 4'hF) begin errors++; $display("FAIL t2_wen got=%h exp=f", rf_wen); end
    checks++; if (rf_wdata !== 32'h12345678) begin errors++; $display("FAIL t2_wdata got=%h exp=12345678", rf_wdata); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after got=%b exp=1", md_ready); end
    tick();
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL t2_second_accept got=%b exp=0", md_ready); end
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t2_bubble_wen got=%h exp=0", rf_wen); end
    md_valid = 1'b0;
    tick();
    checks++; if (rf_waddr !== 5'd8 || rf_wdata !== 32'h0BADF00D) begin errors++; $display("FAIL t2_second_issue got=%0d/%h exp=8/0badf00d", rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve_and_drop();
    md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'h99999999;
    wb_valid = 1'b1; wb_waddr = 5'd3; wb_wen = 4'hF; wb_wdata = 32'h30;
    tick();
    md_valid = 1'b0;
    checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'h30) begin errors++; $display("FAIL t3_accept_wb got=%0d/%h exp=3/30", rf_waddr, rf_wdata); end
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL t3_ready got=%b exp=0", md_ready); end
    for (int i = 0; i < 8; i++) begin
      wb_wdata = 32'h100 + i;
      tick();
      checks++; if (rf_waddr !== 5'd3 || rf_wen !== 4'hF || rf_wdata !== 32'h100 + i) begin errors++; $display("FAIL t3_wb_%0d got=%0d/%h/%h exp=3/f/%h", i, rf_waddr, rf_wen, rf_wdata, 32'h100 + i); end
      checks++; if (pipe_stall !== (i == 7)) begin errors++; $display("FAIL t3_stall_%0d got=%b exp=%b", i, pipe_stall, (i == 7)); end
    end
    wb_waddr = 5'd4; wb_wdata = 32'h44444444;
    tick();
    checks++; if (rf_waddr !== 5'd9 || rf_wen !== 4'hF || rf_wdata !== 32'h99999999) begin errors++; $display("FAIL t3_hold_issue got=%0d/%h/%h exp=9/f/99999999", rf_waddr, rf_wen, rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL t3_stall_clear got=%b exp=0", pipe_stall); end
    checks++; if (wb_drop_err !== 1'b1) begin errors++; $display("FAIL t4_drop_err got=%b exp=1", wb_drop_err); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_back got=%b exp=1", md_ready); end
    idle_inputs();
    tick(); tick();
    checks++; if (wb_drop_err !== 1'b1) begin errors++; $display("FAIL t4_drop_sticky got=%b exp=1", wb_drop_err); end
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t4_no_r4 got=%h exp=0", rf_wen); end
  endtask

  task automatic test_non_effective();
    wb_valid = 1'b1; wb_waddr = 5'd0; wb_wen = 4'hF; wb_wdata = 32'h11111111;
    tick();
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t5_waddr0 got=%h exp=0", rf_wen); end
    wb_waddr = 5'd5; wb_wen = 4'h0;
    tick();
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t5_wen0 got=%h exp=0", rf_wen); end
    idle_inputs();
    md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'h22222222;
    tick();
    md_valid = 1'b0;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL t5_md0_ready got=%b exp=1", md_ready); end
    tick();
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL t5_md0_wen got=%h exp=0", rf_wen); end
  endtask

  task automatic test_reset_mid_op();
    md_valid = 1'b1; md_waddr = 5'd10; md_wdata = 32'hAAAA0000;
    wb_valid = 1'b1; wb_waddr = 5'd11; wb_wen = 4'h3; wb_wdata = 32'h0000BBBB;
    tick();
    idle_inputs();
    checks++; if (rf_wen !== 4'h3) begin errors++; $display("FAIL rst_pre_wen got=%h exp=3", rf_wen); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL rst_async_wen got=%h exp=0", rf_wen); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", md_ready); end
    checks++; if (wb_drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop_clear got=%b exp=0", wb_drop_err); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (rf_wen !== 4'h0) begin errors++; $display("FAIL rst_hold_discard got=%h exp=0", rf_wen); end
  endtask

`ifdef RF_WRITE_ARB_FWD_EN
  task automatic test_forward();
    wb_valid = 1'b1; wb_waddr = 5'd2; wb_wen = 4'h3; wb_wdata = 32'hAABBCCDD;
    tick();
    idle_inputs();
    raddr1 = 5'd2; rf_rdata1 = 32'h11223344;
    raddr2 = 5'd6; rf_rdata2 = 32'h55667788;
    #1;
    checks++; if (fwd_rdata1 !== 32'h1122CCDD) begin errors++; $display("FAIL t6_fwd1 got=%h exp=1122ccdd", fwd_rdata1); end
    checks++; if (fwd_rdata2 !== 32'h55667788) begin errors++; $display("FAIL t6_nofwd2 got=%h exp=55667788", fwd_rdata2); end
    raddr2 = 5'd0;
    #1;
    checks++; if (fwd_rdata2 !== 32'h0) begin errors++; $display("FAIL t6_r0 got=%h exp=0", fwd_rdata2); end
    tick();
    checks++; if (fwd_rdata1 !== 32'h11223344) begin errors++; $display("FAIL t6_wen0 got=%h exp=11223344", fwd_rdata1); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_wb_issue();
    test_md_issue();
    test_starve_and_drop();
    test_non_effective();
    test_reset_mid_op();
`ifdef RF_WRITE_ARB_FWD_EN
    test_forward();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
